ring_arbiter: RTL
=================

// Module: ring_arbiter
// PURPOSE
//  Round-robin arbiter between the N core L1 miss ports and the supercore L2 read port.
//  Sits directly upstream of the L2 controller: one core request is granted at a time.
//  The address is forwarded once, then the L2 beat stream is routed back to the winning core.
//  A one-cycle completion pulse ends each line.
// PARAMETERS
//  N_CORES     4      number of requesting cores (>=2)
//  ADDR_W      64     byte address width
//  DATA_W      64     beat width (8 bytes/beat)
//  LINE_BEATS  8192   beats per L1 fill (64 KB line); power of two
//  TIMEOUT     1024   max idle cycles between beats (used only with RING_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               asynchronous, active-low reset
//  c_req      in   N_CORES         per-core fill request, level, held until c_ready
//  c_addr     in   N_CORES*ADDR_W  per-core fill address, core i at [i*ADDR_W +: ADDR_W]
//  c_ready    out  N_CORES         one-cycle pulse: line for core i complete
//  c_rvalid   out  N_CORES         beat valid, one-hot to the granted core
//  c_rdata    out  DATA_W          beat data, shared bus
//  l2_req     out  1               request to L2 controller
//  l2_addr    out  ADDR_W          line-aligned address: addr & ~(LINE_BEATS*8-1)
//  l2_gnt     in   1               L2 accepts; handshake = l2_req & l2_gnt
//  l2_rvalid  in   1               L2 beat valid
//  l2_rdata   in   DATA_W          L2 beat data
//  arb_err    out  1               timeout pulse; constant 0 when feature compiled out
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, state IDLE, rr_ptr=0, beat_cnt=0, owner=0.
//  FSM: IDLE -> REQ -> STREAM -> DONE -> IDLE.
//  IDLE:   if any c_req, pick the first requester scanning from rr_ptr upward (mod N).
//          Latch owner and aligned address; l2_req=1 and l2_addr valid next cycle; go to REQ.
//  REQ:    hold l2_req and l2_addr stable until l2_gnt.
//          On the handshake cycle go to STREAM; l2_req=0 the following cycle.
//  STREAM: each l2_rvalid beat is registered. c_rdata and c_rvalid[owner] assert exactly one
//          cycle after the beat; beat_cnt increments.
//          The beat with beat_cnt==LINE_BEATS-1 moves the FSM to DONE.
//          l2_rvalid outside STREAM is ignored.
//  DONE:   c_ready[owner]=1 for one cycle, in the same cycle as the last c_rvalid.
//          rr_ptr=(owner+1) mod N; beat_cnt=0; return to IDLE.
//          Min turnaround: the next grant is sampled in the IDLE cycle after DONE.
//  Owner drops c_req mid-line: the line still completes; beats and c_ready go to owner (no abort).
//  c_req from other cores during a line: ignored until IDLE; no pending queue.
//  Simultaneous requests: strict rotation; no core waits more than N_CORES-1 lines.
//  c_addr changes after grant: ignored; the address is latched in IDLE.
//  Reset mid-line: immediate abort, no c_ready issued; L2 must also be reset.
//  Widths: beat_cnt is $clog2(LINE_BEATS) bits, wraps to 0 only via DONE.
//          rr_ptr is $clog2(N_CORES) bits.
// CONFIGURATION
//  RING_ARB_TIMEOUT_EN defined:
//   - A watchdog counts cycles in REQ/STREAM with no handshake and no l2_rvalid.
//   - On reaching TIMEOUT: arb_err pulses for one cycle, c_ready[owner] pulses, and the FSM
//     goes to IDLE with rr_ptr advanced.
//   - The watchdog clears on every handshake or beat.
//  Not defined: no watchdog logic; arb_err tied 0; the FSM waits indefinitely.
// STRUCTURE
//  ring_pkg: arb_state_t enum {IDLE,REQ,STREAM,DONE}; LINE_BYTES, beat/ptr width
//            constants; align_line() function.
//  Sub-module rr_pick: combinational rotate-priority picker
//   - in:  req[N], ptr
//   - out: gnt_idx, gnt_any
//   - instantiated once.
//  Everything else (FSM, counters, data register) lives in ring_arbiter.
// TESTING
//  (bench: N_CORES=4, LINE_BEATS=8, TIMEOUT=16)
//  1. Single request, then beats:
//     c_req=0010, c_addr[1]=0x1234, l2_gnt next cycle, 8 beats 0..7
//     -> l2_addr=0x1200 (line 64B)
//     -> c_rvalid=0010 x8 with data 0..7, each 1 cycle after its beat
//     -> c_ready[1] with beat 7; rr_ptr=2.
//  2. Contention:
//     all c_req=1111 held, rr_ptr=0
//     -> grant order 0,1,2,3,0; no overlap of c_rvalid between lines.
//  3. Gapped stream:
//     l2_gnt delayed 5 cycles, beats with gaps
//     -> l2_req/l2_addr stable through the delay; still exactly 8 c_rvalid, one c_ready.
//  4. Owner withdraws:
//     owner drops c_req after beat 2
//     -> remaining beats and c_ready still delivered to the owner; next grant by rotation.
//  5. Reset mid-stream:
//     rst low at beat 4
//     -> outputs 0 asynchronously; after release, c_req=0001 is granted from rr_ptr=0.
//  6. Timeout (RING_ARB_TIMEOUT_EN):
//     gnt given, no beats for 16 cycles
//     -> arb_err and c_ready[owner] one-cycle pulses, back to IDLE.
//     Without the macro: arb_err stays 0 and the FSM holds in STREAM.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring arbiter: FSM state, beat geometry,
// counter-width helper and line-address alignment.
// Pure declarations, no logic of its own.
package ring_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam int unsigned BEAT_BYTES     = 8;
  localparam int unsigned DEF_LINE_BEATS = 8192;
  localparam int unsigned LINE_BYTES     = DEF_LINE_BEATS * BEAT_BYTES;

  // Width of a counter/index covering 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Clear the in-line byte offset; line_bytes must be a power of two
  function automatic logic [63:0] align_line(input logic [63:0] addr,
                                             input int unsigned line_bytes);
    return addr & ~(64'(line_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/ring_arbiter_rr_pick.sv
// Rotate-priority picker: first asserted req at or above ptr, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on gnt_idx.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [PTR_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester after ptr wins
  always_comb begin
    gnt_idx = ptr;
    cand    = ptr;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      cand = PTR_W'((int'(ptr) + i) % int'(N));
      if (req[cand]) gnt_idx = cand;
    end
  end

  assign gnt_any = |req;

endmodule

// File: rtl/ring_arbiter.sv
// Round-robin arbiter of N core fill requests onto one L2 read port; beats routed back to owner.
// Latency: l2_req one cycle after a request is seen in IDLE; each c_rvalid one cycle after l2_rvalid.
// Backpressure: l2_req held until l2_gnt; no beat backpressure. Optional watchdog: RING_ARB_TIMEOUT_EN.
module ring_arbiter
  import ring_pkg::*;
#(
  parameter int unsigned N_CORES    = 4,
  parameter int unsigned ADDR_W     = 64,   // at most 64
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LINE_BEATS = DEF_LINE_BEATS,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CORES-1:0]          c_req,
  input  logic [N_CORES*ADDR_W-1:0]   c_addr,
  output logic [N_CORES-1:0]          c_ready,
  output logic [N_CORES-1:0]          c_rvalid,
  output logic [DATA_W-1:0]           c_rdata,
  output logic                        l2_req,
  output logic [ADDR_W-1:0]           l2_addr,
  input  logic                        l2_gnt,
  input  logic                        l2_rvalid,
  input  logic [DATA_W-1:0]           l2_rdata,
  output logic                        arb_err
);

  localparam int unsigned       PTR_W     = cnt_w(N_CORES);
  localparam int unsigned       BEAT_W    = cnt_w(LINE_BEATS);
  // Aligning an all-ones address yields the line mask itself
  localparam logic [63:0]       MASK64    = align_line('1, LINE_BEATS * BEAT_BYTES);
  localparam logic [ADDR_W-1:0] LINE_MASK = MASK64[ADDR_W-1:0];
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [PTR_W-1:0]  LAST_CORE = PTR_W'(N_CORES - 1);

  arb_state_t          state_q, state_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;
  logic [N_CORES-1:0]  owner_oh;
  logic                wd_fire;
  logic [ADDR_W-1:0]   addr_arr [N_CORES];

  for (genvar g = 0; g < N_CORES; g++) begin : g_addr
    assign addr_arr[g] = c_addr[g*ADDR_W +: ADDR_W];
  end

  rr_pick #(
    .N     (N_CORES),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (c_req),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

`ifdef RING_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = cnt_w(TIMEOUT);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  // Count consecutive dead cycles while waiting on L2; fire on the TIMEOUT-th
  always_comb begin
    wd_d    = '0;
    err_d   = 1'b0;
    wd_fire = 1'b0;
    if (state_q == REQ || state_q == STREAM) begin
      if ((state_q == REQ && l2_gnt) || l2_rvalid) begin
        wd_d = '0;
      end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
        wd_fire = 1'b1;
        err_d   = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  // Watchdog counter and error pulse register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign arb_err = err_q;
`else
  logic unused_timeout;

  assign wd_fire        = 1'b0;
  assign arb_err        = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // Next state plus grant latch, beat register, beat counter and pointer rotation
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          addr_d  = addr_arr[pick_idx] & LINE_MASK;
          state_d = REQ;
        end
      end
      REQ: begin
        if (wd_fire)     state_d = DONE;
        else if (l2_gnt) state_d = STREAM;
      end
      STREAM: begin
        if (l2_rvalid) begin
          rvalid_d = 1'b1;
          rdata_d  = l2_rdata;
          // Counter parks on the last index; DONE is the only place it returns to 0
          if (beat_cnt_q == LAST_BEAT) state_d = DONE;
          else                         beat_cnt_d = beat_cnt_q + 1'b1;
        end else if (wd_fire) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rr_ptr_d   = (owner_q == LAST_CORE) ? '0 : owner_q + 1'b1;
        beat_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers; reset mid-line drops the line without a completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign owner_oh = {{(N_CORES-1){1'b0}}, 1'b1} << owner_q;
  assign l2_req   = (state_q == REQ);
  assign l2_addr  = addr_q;
  assign c_rvalid = rvalid_q ? owner_oh : '0;
  // DONE coincides with the registered copy of the last beat
  assign c_ready  = (state_q == DONE) ? owner_oh : '0;
  assign c_rdata  = rdata_q;

endmodule
